// File: rtl/recip_sched_pkg.sv
// Shared types and constants for the reciprocal-unit scheduler.
// Holds the FSM state encoding, the default operand widths and the saturated result value.
package recip_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEN_W_DEF = 10;
    localparam int RCP_W_DEF = 11;
    localparam int TIMEOUT_W = 6;

    // Wide enough for any result width; the top slices off what it needs.
    localparam logic [31:0] RECIP_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/recip_sched_rr.sv
// Combinational round-robin picker: returns the first asserted request at or after ptr,
// wrapping modulo NREQ, as a one-hot grant plus its index.
module rr_pick
    import recip_sched_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any                               = 1'b1;
                grant[(int'(ptr) + k) % NREQ]     = 1'b1;
                idx                               = IDX_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/recip_sched.sv
// Shares one iterative reciprocal divider between NREQ requesters with round-robin arbitration
// and a hang timeout. Define RECIP_SCHED_CACHE_EN to add a single-entry result cache.
module recip_sched
    import recip_sched_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int DEN_W   = DEN_W_DEF,
    parameter int RCP_W   = RCP_W_DEF,
    parameter int TIMEOUT = 63
) (
    input  logic                  clk48,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DEN_W-1:0] req_denom,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [RCP_W-1:0]      rsp_recip,
    output logic                  rsp_err,
    output logic                  div_start,
    output logic [DEN_W-1:0]      div_denom,
    input  logic                  div_done,
    input  logic [RCP_W-1:0]      div_recip,
    output logic                  busy
);

    localparam int IDX_W = (NREQ > 2) ? 2 : 1;
    localparam logic [RCP_W-1:0] SAT = RECIP_SAT[RCP_W-1:0];

    state_t               state;
    state_t               state_nx;
    logic [IDX_W-1:0]     sel_q;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     pick_idx;
    logic [NREQ-1:0]      pick_grant;
    logic                 pick_any;
    logic [DEN_W-1:0]     pick_denom;
    logic [DEN_W-1:0]     denom_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [RCP_W-1:0]     recip_q;
    logic                 err_q;
    logic                 timed_out;
    logic                 hit;
    logic [RCP_W-1:0]     hit_data;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_denom = req_denom[int'(pick_idx)*DEN_W +: DEN_W];
    // The counter has already spent TIMEOUT-1 WAIT cycles; this cycle is the last one.
    assign timed_out  = (state == WAIT) && (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

`ifdef RECIP_SCHED_CACHE_EN
    logic [DEN_W-1:0] cache_tag;
    logic [RCP_W-1:0] cache_data;
    logic             cache_vld;

    // Only genuine divider completions are remembered; error results never are.
    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            cache_tag  <= '0;
            cache_data <= '0;
            cache_vld  <= 1'b0;
        end else if (state == WAIT && div_done) begin
            cache_tag  <= denom_q;
            cache_data <= div_recip;
            cache_vld  <= 1'b1;
        end
    end

    assign hit      = cache_vld && (cache_tag == pick_denom);
    assign hit_data = cache_data;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = (pick_denom == '0 || hit) ? RESP : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (div_done || timed_out) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    req_ready = pick_grant;
            ISSUE:   div_start = 1'b1;
            RESP:    rsp_valid[sel_q] = 1'b1;
            default: ;
        endcase
    end

    // Datapath: a done in the timeout cycle takes priority over the forced error.
    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            sel_q   <= '0;
            rr_ptr  <= '0;
            denom_q <= '0;
            cnt_q   <= '0;
            recip_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        sel_q   <= pick_idx;
                        denom_q <= pick_denom;
                        if (pick_denom == '0) begin
                            recip_q <= SAT;
                            err_q   <= 1'b1;
                        end else if (hit) begin
                            recip_q <= hit_data;
                            err_q   <= 1'b0;
                        end
                    end
                end
                ISSUE: cnt_q <= '0;
                WAIT: begin
                    if (div_done) begin
                        recip_q <= div_recip;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        recip_q <= SAT;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: rr_ptr <= (sel_q == IDX_W'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign div_denom = denom_q;
    assign rsp_recip = recip_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_recip_sched.sv
// Scoreboard bench for recip_sched: a divider model (latency 17) plus a reference model
// predicting grant order, results and latencies; a monitor checks every DUT output event.
module tb_recip_sched;

    localparam int NREQ    = 3;
    localparam int DEN_W   = 10;
    localparam int RCP_W   = 11;
    localparam int TIMEOUT = 63;
    localparam int DIV_LAT = 17;
    localparam int SAT     = 2047;

    logic                  clk48 = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DEN_W-1:0] req_denom = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [RCP_W-1:0]      rsp_recip;
    logic                  rsp_err;
    logic                  div_start;
    logic [DEN_W-1:0]      div_denom;
    logic                  div_done = 1'b0;
    logic [RCP_W-1:0]      div_recip = '0;
    logic                  busy;

    typedef struct {
        int idx;
        int recip;
        int err;
        bit from_start;
        int lat;
    } exp_t;

    exp_t rsp_q[$];
    int   start_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   model_ptr = 0;
    bit   div_hang = 1'b0;
    bit   inject_done = 1'b0;
`ifdef RECIP_SCHED_CACHE_EN
    bit   cache_vld = 1'b0;
    int   cache_tag = 0;
    int   cache_data = 0;
`endif

    always #5 clk48 = ~clk48;
    always @(posedge clk48) cyc <= cyc + 1;

    recip_sched #(
        .NREQ    (NREQ),
        .DEN_W   (DEN_W),
        .RCP_W   (RCP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk48     (clk48),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_denom (req_denom),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_recip (rsp_recip),
        .rsp_err   (rsp_err),
        .div_start (div_start),
        .div_denom (div_denom),
        .div_done  (div_done),
        .div_recip (div_recip),
        .busy      (busy)
    );

    function automatic int ref_recip(input int d);
        int r;
        if (d == 0) return SAT;
        r = 16384 / d;
        return (r > SAT) ? SAT : r;
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name, input int act);
        total++;
        bad++;
        $display("[TB] FAIL %s: actual=%0d required=none (cycle %0d)", name, act, cyc);
    endtask

    // Reference model of one accepted request, called in the order grants must occur.
    task automatic push_expect(input int idx, input int den);
        exp_t e;
        e.idx = idx;
        e.err = 0;
        e.from_start = 1'b0;
        e.lat = DIV_LAT + 3;
        e.recip = 0;
        if (den == 0) begin
            e.recip = SAT;
            e.err = 1;
            e.lat = 2;
        end
`ifdef RECIP_SCHED_CACHE_EN
        else if (cache_vld && cache_tag == den) begin
            e.recip = cache_data;
            e.lat = 2;
        end
`endif
        else if (div_hang) begin
            start_q.push_back(den);
            e.recip = SAT;
            e.err = 1;
            e.from_start = 1'b1;
            e.lat = TIMEOUT + 1;
        end else begin
            start_q.push_back(den);
            e.recip = ref_recip(den);
`ifdef RECIP_SCHED_CACHE_EN
            cache_vld = 1'b1;
            cache_tag = den;
            cache_data = e.recip;
`endif
        end
        rsp_q.push_back(e);
        model_ptr = (idx + 1) % NREQ;
    endtask

    task automatic apply_stimulus(input int idx, input int den);
        int waited;
        waited = 0;
        @(posedge clk48);
        #1;
        req_valid[idx] = 1'b1;
        req_denom[idx*DEN_W +: DEN_W] = DEN_W'(den);
        do begin
            @(negedge clk48);
            waited++;
        end while (!req_ready[idx] && waited < 400);
        if (!req_ready[idx]) report_fail("ready_timeout", idx);
        @(posedge clk48);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int idx);
        int waited;
        waited = 0;
        do begin
            @(negedge clk48);
            waited++;
        end while (!rsp_valid[idx] && waited < 400);
        if (!rsp_valid[idx]) report_fail("rsp_wait_timeout", idx);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || start_q.size() != 0) && n < 400) begin
            @(negedge clk48);
            n++;
        end
        check_output("drain_pending", rsp_q.size() + start_q.size(), 0);
        rsp_q.delete();
        start_q.delete();
        repeat (3) @(negedge clk48);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_busy", busy, 0);
        check_output("rst_req_ready", req_ready, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_div_start", div_start, 0);
        check_output("rst_rsp_err", rsp_err, 0);
        check_output("rst_rsp_recip", rsp_recip, 0);
        check_output("rst_div_denom", div_denom, 0);
    endtask

    // Divider model: done arrives DIV_LAT cycles after the start cycle, unless hung.
    initial begin : divider_model
        int  left;
        int  den;
        bit  pending;
        left = 0;
        den = 0;
        pending = 1'b0;
        forever begin
            @(negedge clk48);
            div_done = 1'b0;
            if (pending) begin
                left--;
                if (left == 0) begin
                    pending = 1'b0;
                    div_done = 1'b1;
                    div_recip = RCP_W'(ref_recip(den));
                end
            end
            if (inject_done) begin
                inject_done = 1'b0;
                div_done = 1'b1;
                div_recip = RCP_W'(5);
            end
            if (div_start === 1'b1 && !div_hang) begin
                pending = 1'b1;
                left = DIV_LAT;
                den = int'(div_denom);
            end
        end
    end

    initial begin : monitor
        int   acc_cyc;
        int   start_cyc;
        exp_t e;
        acc_cyc = 0;
        start_cyc = 0;
        forever begin
            @(negedge clk48);
            if (rst_n) begin
                if (|req_ready) begin
                    acc_cyc = cyc;
                    check_output("ready_onehot", $countones(req_ready), 1);
                end
                if (div_start === 1'b1) begin
                    start_cyc = cyc;
                    if (start_q.size() == 0) report_fail("spurious_div_start", int'(div_denom));
                    else check_output("div_denom", div_denom, start_q.pop_front());
                end
                if (|rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        report_fail("spurious_rsp_valid", int'(rsp_valid));
                    end else begin
                        e = rsp_q.pop_front();
                        check_output("rsp_valid_grant", rsp_valid, 1 << e.idx);
                        check_output("rsp_recip", rsp_recip, e.recip);
                        check_output("rsp_err", rsp_err, e.err);
                        check_output("rsp_latency", e.from_start ? cyc - start_cyc : cyc - acc_cyc + 1, e.lat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] pend_mask;
        int d[NREQ];
        int pend[NREQ];
        int sel;

        rst_n = 1'b0;
        repeat (3) @(posedge clk48);
        @(negedge clk48);
        check_reset_outputs();
        @(posedge clk48);
        #1 rst_n = 1'b1;

        // Single requester, saturated then exact result.
        push_expect(1, 8);
        apply_stimulus(1, 8);
        drain();
        push_expect(1, 16);
        apply_stimulus(1, 16);
        drain();

        // Zero denominator bypasses the divider.
        push_expect(2, 0);
        apply_stimulus(2, 0);
        drain();

        // All three contend; requester 0 comes back right after its response.
        d = '{33, 100, 500};
        pend = '{2, 1, 1};
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NREQ; i++) pend_mask[i] = (pend[i] > 0);
            sel = model_pick(pend_mask);
            push_expect(sel, d[sel]);
            pend[sel]--;
        end
        fork
            begin
                apply_stimulus(0, 33);
                wait_rsp(0);
                apply_stimulus(0, 33);
            end
            apply_stimulus(1, 100);
            apply_stimulus(2, 500);
        join
        drain();

        // Hung divider forces a timeout; a late done afterwards must be ignored.
        div_hang = 1'b1;
        push_expect(0, 300);
        apply_stimulus(0, 300);
        drain();
        @(posedge clk48);
        #1 inject_done = 1'b1;
        repeat (6) @(negedge clk48);
        div_hang = 1'b0;

        // Reset mid-WAIT: the in-flight request vanishes and the pointer restarts at 0.
        start_q.push_back(50);
        apply_stimulus(1, 50);
        repeat (5) @(posedge clk48);
        #1 rst_n = 1'b0;
        @(posedge clk48);
        #1 rst_n = 1'b1;
        @(negedge clk48);
        check_reset_outputs();
        model_ptr = 0;
`ifdef RECIP_SCHED_CACHE_EN
        cache_vld = 1'b0;
`endif
        repeat (25) @(negedge clk48);
        check_output("post_rst_idle", busy, 0);
        d = '{70, 90, 110};
        pend_mask = '1;
        while (pend_mask != '0) begin
            sel = model_pick(pend_mask);
            push_expect(sel, d[sel]);
            pend_mask[sel] = 1'b0;
        end
        fork
            apply_stimulus(0, 70);
            apply_stimulus(1, 90);
            apply_stimulus(2, 110);
        join
        drain();

        // Repeated denominator (served from the cache when it is built in).
        push_expect(0, 64);
        apply_stimulus(0, 64);
        drain();
        push_expect(0, 64);
        apply_stimulus(0, 64);
        drain();

        // Randomized contention rounds.
        for (int r = 0; r < 12; r++) begin
            mask = NREQ'($urandom_range(1, 7));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 5))
                    0:       d[i] = 0;
                    1, 2:    d[i] = ($urandom_range(0, 1) != 0) ? 64 : 200;
                    default: d[i] = int'($urandom_range(1, 1023));
                endcase
            end
            pend_mask = mask;
            while (pend_mask != '0) begin
                sel = model_pick(pend_mask);
                push_expect(sel, d[sel]);
                pend_mask[sel] = 1'b0;
            end
            fork
                if (mask[0]) apply_stimulus(0, d[0]);
                if (mask[1]) apply_stimulus(1, d[1]);
                if (mask[2]) apply_stimulus(2, d[2]);
            join
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recip_sched.md
Name: recip_sched

Overview:
- Schedules a single shared iterative reciprocal unit (the plane-projection divider) between NREQ requesters, e.g. plane rows, scroller wobble and starfield depth.
- Round-robin arbitration with a valid/ready request handshake.
- Sequences the divider's start/done protocol, returns the result to the granted requester, and guards against divider hang with a timeout.
- Sits between the effect generators and one divider instance, all in the clk48 domain.

Parameters:
- NREQ, 3, number of requesters (2..4)
- DEN_W, 10, denominator width
- RCP_W, 11, reciprocal result width
- TIMEOUT, 63, max cycles waiting for div_done before forced response (6-bit counter)

Ports:
- clk48  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_denom  in  NREQ*DEN_W  packed denominators; requester i at [i*DEN_W +: DEN_W]
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot result pulse
- rsp_recip  out  RCP_W  result; valid with rsp_valid, held until next response
- rsp_err  out  1  qualifies rsp_valid: timeout or zero denominator
- div_start  out  1  one-cycle start to divider
- div_denom  out  DEN_W  operand to divider; stable from div_start until div_done or timeout
- div_done  in  1  divider completion pulse
- div_recip  in  RCP_W  divider result; valid with div_done
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n=0 at clk48 edge), any state: go to IDLE.
  - req_ready, rsp_valid, div_start, rsp_err, busy = 0.
  - rsp_recip = 0, div_denom = 0.
  - rr pointer = 0, timeout counter = 0.
  - A div_done arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, select the first asserted index starting at rr_ptr, wrapping modulo NREQ.
  - Same cycle: req_ready[sel]=1 (combinational from registered state and req_valid); latch sel and denom at the edge.
  - Latched denom==0: skip the divider, go to RESP with result all-ones and rsp_err=1.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_start=1 for exactly one cycle; div_denom = latched denom.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - On div_done: latch div_recip, err=0, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT with no done: result all-ones, err=1, go to RESP.
  - div_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[sel]=1 for one cycle; rsp_recip and rsp_err update at the transition into RESP.
  - rr_ptr = (sel+1) mod NREQ; go to IDLE.
- div_done outside WAIT: ignored.
- Requester protocol: hold req_valid and req_denom until req_ready. Deasserting req_valid before ready drops the request with no effect.
  - A requester may reassert in the cycle after its rsp_valid.
  - A request accepted during the RESP cycle is impossible: req_ready is only ever asserted in IDLE.
- Latency from accept to rsp_valid: divider latency L + 3 cycles (accept edge, ISSUE, WAIT..done edge, RESP). Zero-denom path: 2 cycles.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,0,...
- At most one req_ready, rsp_valid and div_start bit high per cycle.

Optional Feature:
- Macro RECIP_SCHED_CACHE_EN.
- With it: single-entry result cache (tag = denom, data, valid bit), cleared on reset.
  - In IDLE, if latched denom equals the tag and valid=1: go directly to RESP with cached data; no div_start.
  - The cache is filled on every div_done completion. Zero-denom and timeout results are never cached.
- Without it: every nonzero request issues div_start.

Decomposition:
- Shared package recip_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - DEN_W, RCP_W defaults
  - RECIP_SAT constant (all-ones)
  - TIMEOUT_W = 6
- One sub-module rr_pick: combinational round-robin picker.
  - Inputs: NREQ request vector, pointer.
  - Outputs: one-hot grant and index.

Test Plan:
- Divider model: latency 17, recip = min(2047, 16384/denom). req1 denom=8 alone -> req_ready[1] pulse, div_start once with div_denom=8, rsp_valid[1] 20 cycles after accept, rsp_recip=2047 (saturated), rsp_err=0. Then req1 denom=16 -> rsp_recip=1024, rsp_err=0.
- All three valid continuously with denoms 33, 100, 500 -> grant order 0,1,2,0; rsp_recip 496, 163, 32; never two rsp_valid bits in one cycle.
- req2 denom=0 -> no div_start; rsp_valid[2] 2 cycles after accept; rsp_recip=2047; rsp_err=1.
- Divider model never asserts done -> rsp_valid exactly TIMEOUT+1 cycles after div_start with rsp_recip=2047, rsp_err=1. A late div_done in IDLE is ignored: no spurious rsp_valid.
- rst_n low for 1 cycle mid-WAIT -> all outputs 0 next cycle, busy=0. A following div_done is ignored. The next request is granted to requester 0 first (rr_ptr=0).
- With RECIP_SCHED_CACHE_EN: two requests with denom=64 back to back -> first issues div_start, second gets rsp_recip=256 with no div_start, 2 cycles after accept.
